mips_control_fsm: RTL and testbench

MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

---
 rtl/mips_control_fsm_if.sv | 35 +++
 rtl/mips_control_fsm.sv | 156 +++++++++++++++
 tb/tb_mips_control_fsm.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_control_fsm_if.sv
// rtl/mips_control_fsm_if.sv - opcode in, control word out, between the multicycle datapath and its control FSM
//
// master : the control FSM (samples opcode, drives enables, mux selects, debug state, trap flag)
// slave  : the datapath side (drives opcode, consumes the control word)
interface mips_control_fsm_if;
    logic [5:0] opcode;
    logic       IorD;
    logic       IRWrite;
    logic       MemWrite;
    logic       PCWrite;
    logic       Branch;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic [1:0] ALUOp;
    logic [3:0] state;
    logic       illegal_op;

    modport master (
        input  opcode,
        output IorD, IRWrite, MemWrite, PCWrite, Branch, RegWrite,
        output RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc, ALUOp,
        output state, illegal_op
    );

    modport slave (
        output opcode,
        input  IorD, IRWrite, MemWrite, PCWrite, Branch, RegWrite,
        input  RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc, ALUOp,
        input  state, illegal_op
    );
endinterface

// File: rtl/mips_control_fsm.sv
// rtl/mips_control_fsm.sv - Moore control FSM for a multicycle MIPS subset (lw, sw, R-type, beq, addi, j)
//
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : mips_control_fsm_if.master (opcode in; control word, debug state, illegal_op out)
// Optional feature: define ILLEGAL_OP_TRAP_EN to park unsupported opcodes in ERROR
// (illegal_op=1) until reset; otherwise they fall back to FETCH and illegal_op is 0.
module mips_control_fsm (
    input  logic                     clk,
    input  logic                     rst_n,
    mips_control_fsm_if.master       bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11,
        ERROR    = 4'd15
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef struct packed {
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       pc_write;
        logic       branch;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
`ifdef ILLEGAL_OP_TRAP_EN
        logic       illegal_op;
`endif
    } ctrl_t;

    // Opcode only matters in DECODE and MEMADR; every other state has a fixed successor.
    function automatic state_t next_state(input state_t s, input logic [5:0] op);
        case (s)
            FETCH:    return DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: return MEMADR;
                    OP_RT:        return EXECUTE;
                    OP_BEQ:       return BRANCH;
                    OP_ADDI:      return ADDIEXEC;
                    OP_J:         return JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:      return ERROR;
`else
                    default:      return FETCH;
`endif
                endcase
            end
            MEMADR:   return (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:    return MEMWB;
            EXECUTE:  return ALUWB;
            ADDIEXEC: return ADDIWB;
`ifdef ILLEGAL_OP_TRAP_EN
            ERROR:    return ERROR;
`endif
            // write-back/terminal states and the unused codes 12-14 all restart
            default:  return FETCH;
        endcase
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b01; end
            DECODE:   begin c.alu_src_b = 2'b11; end
            MEMADR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            MEMRD:    begin c.iord = 1'b1; end
            MEMWB:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
            MEMWR:    begin c.iord = 1'b1; c.mem_write = 1'b1; end
            EXECUTE:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            ALUWB:    begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
            BRANCH:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.branch = 1'b1; end
            ADDIEXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            ADDIWB:   begin c.reg_write = 1'b1; end
            JUMP:     begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
`ifdef ILLEGAL_OP_TRAP_EN
            ERROR:    begin c.illegal_op = 1'b1; end
`endif
            default:  c = '0;
        endcase
        return c;
    endfunction

    state_t state_q;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_view;

    // ctrl_q is loaded with the decode of the state being entered, so it always
    // equals decode_ctrl(state_q) without any combinational decode on the output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            ctrl_q  <= decode_ctrl(FETCH);
        end else begin
            state_q <= next_state(state_q, bus.opcode);
            ctrl_q  <= decode_ctrl(next_state(state_q, bus.opcode));
        end
    end

    // While reset is held nothing may write: enables are masked, selects show FETCH.
    // Once rst_n rises the registered FETCH word goes live so FETCH executes on
    // the first released edge.
    always_comb begin
        ctrl_view = ctrl_q;
        if (!rst_n) begin
            ctrl_view           = '0;
            ctrl_view.alu_src_b = 2'b01;
        end
    end

    assign bus.IorD     = ctrl_view.iord;
    assign bus.IRWrite  = ctrl_view.ir_write;
    assign bus.MemWrite = ctrl_view.mem_write;
    assign bus.PCWrite  = ctrl_view.pc_write;
    assign bus.Branch   = ctrl_view.branch;
    assign bus.RegWrite = ctrl_view.reg_write;
    assign bus.RegDst   = ctrl_view.reg_dst;
    assign bus.MemtoReg = ctrl_view.mem_to_reg;
    assign bus.ALUSrcA  = ctrl_view.alu_src_a;
    assign bus.ALUSrcB  = ctrl_view.alu_src_b;
    assign bus.PCSrc    = ctrl_view.pc_src;
    assign bus.ALUOp    = ctrl_view.alu_op;
    assign bus.state    = state_q;
`ifdef ILLEGAL_OP_TRAP_EN
    assign bus.illegal_op = ctrl_view.illegal_op;
`else
    assign bus.illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_mips_control_fsm.sv
// tb/tb_mips_control_fsm.sv - directed and randomized self-checking bench for mips_control_fsm
module tb_mips_control_fsm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_control_fsm_if bus();

    mips_control_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return (op == LW) || (op == SW) || (op == RT) || (op == BEQ) || (op == ADDI) || (op == JMP);
    endfunction

    function automatic int exp_latency(input logic [5:0] d, input logic [5:0] a);
        case (d)
            LW, SW:    return (a == LW) ? 5 : 4;
            RT, ADDI:  return 4;
            BEQ, JMP:  return 3;
            default:   return 2;
        endcase
    endfunction

    // Expected control word for a state code, straight from the per-state output table.
    function automatic logic [15:0] exp_ctrl(input int s, input logic rn);
        logic iord = 0, irw = 0, memw = 0, pcw = 0, br = 0, regw = 0, rdst = 0, m2r = 0, srca = 0, ill = 0;
        logic [1:0] srcb = 0, pcsrc = 0, aluop = 0;
        if (!rn) begin
            srcb = 2'b01;
        end else begin
            case (s)
                0:  begin irw = 1; pcw = 1; srcb = 2'b01; end
                1:  srcb = 2'b11;
                2:  begin srca = 1; srcb = 2'b10; end
                3:  iord = 1;
                4:  begin m2r = 1; regw = 1; end
                5:  begin iord = 1; memw = 1; end
                6:  begin srca = 1; aluop = 2'b10; end
                7:  begin rdst = 1; regw = 1; end
                8:  begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; br = 1; end
                9:  begin srca = 1; srcb = 2'b10; end
                10: regw = 1;
                11: begin pcsrc = 2'b10; pcw = 1; end
                15: ill = 1;
                default: ;
            endcase
        end
        return {iord, irw, memw, pcw, br, regw, rdst, m2r, srca, srcb, pcsrc, aluop, ill};
    endfunction

    // ---------------- behavioural model: remaining route of the current instruction
    int         m_state = 0;
    bit         m_valid = 0;
    int         m_path[$];
    int         m_nxt;
    logic [5:0] m_dec_op = 6'h0;
    logic [5:0] m_adr_op = 6'h0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_state = 0;
            m_path.delete();
            m_valid = 1;
        end else if (m_valid) begin
            if (m_state == 15) begin
                m_nxt = 15;
            end else begin
                if (m_state == 1) begin
                    m_dec_op = bus.opcode;
                    m_path.delete();
                    case (bus.opcode)
                        LW, SW: m_path.push_back(2);
                        RT:     begin m_path.push_back(6); m_path.push_back(7); end
                        BEQ:    m_path.push_back(8);
                        ADDI:   begin m_path.push_back(9); m_path.push_back(10); end
                        JMP:    m_path.push_back(11);
                        default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                            m_path.push_back(15);
`endif
                        end
                    endcase
                end
                if (m_state == 2) begin
                    m_adr_op = bus.opcode;
                    m_path.delete();
                    if (bus.opcode == LW) begin m_path.push_back(3); m_path.push_back(4); end
                    else m_path.push_back(5);
                end
                if (m_state == 0) m_nxt = 1;
                else if (m_path.size() > 0) m_nxt = m_path.pop_front();
                else m_nxt = 0;
            end
            m_state = m_nxt;
        end
    end

    // ---------------- compare process
    int prev_state = -1;
    int lat_cycles = 0;
    bit lat_clean  = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            check("state", {28'h0, bus.state}, m_state);
            check("ctrl_word",
                  {16'h0, bus.IorD, bus.IRWrite, bus.MemWrite, bus.PCWrite, bus.Branch, bus.RegWrite,
                   bus.RegDst, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.ALUOp, bus.illegal_op},
                  {16'h0, exp_ctrl(m_state, rst_n)});
            check("regwrite_memwrite_excl", {31'h0, bus.RegWrite & bus.MemWrite}, 0);
            check("pcwrite_branch_excl", {31'h0, bus.PCWrite & bus.Branch}, 0);
            lat_cycles++;
            if (!rst_n) lat_clean = 0;
            if (bus.state == 4'd0) begin
                if (prev_state != 0 && lat_clean)
                    check("latency", lat_cycles, exp_latency(m_dec_op, m_adr_op));
                lat_cycles = 0;
                lat_clean  = rst_n;
            end
            prev_state = int'(bus.state);
        end
    end

    // ---------------- stimulus
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dir_instr(input logic [5:0] op, input logic [23:0] seq, input int n, input string name);
        bus.opcode = op;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d]", name, i), {28'h0, bus.state}, {28'h0, seq[4*(n-1-i) +: 4]});
            if (i < n - 1) step();
        end
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] op;
        case ($urandom_range(0, 6))
            0: op = LW;
            1: op = SW;
            2: op = RT;
            3: op = BEQ;
            4: op = ADDI;
            5: op = JMP;
            default: begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end
        endcase
        return op;
    endfunction

    logic [5:0] cur_op = LW;
    int hold = 0;
    int err_cycles = 0;

    initial begin
        bus.opcode = 6'h0;
        rst_n = 1'b0;
        step();
        step();
        check("reset_state", {28'h0, bus.state}, 0);
        check("reset_pcwrite", {31'h0, bus.PCWrite}, 0);
        check("reset_irwrite", {31'h0, bus.IRWrite}, 0);
        rst_n = 1'b1;

        dir_instr(LW,   24'h012340, 6, "lw_seq");
        dir_instr(SW,   24'h001250, 5, "sw_seq");
        dir_instr(BEQ,  24'h000180, 4, "beq_seq");
        dir_instr(JMP,  24'h0001b0, 4, "j_seq");
        dir_instr(RT,   24'h001670, 5, "rtype_seq");
        dir_instr(ADDI, 24'h0019a0, 5, "addi_seq");

        bus.opcode = 6'h3f;
        step();
        check("illegal_decode", {28'h0, bus.state}, 1);
        step();
`ifdef ILLEGAL_OP_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            check("illegal_state", {28'h0, bus.state}, 15);
            check("illegal_flag", {31'h0, bus.illegal_op}, 1);
            step();
        end
        rst_n = 1'b0;
        step();
        check("illegal_reset_state", {28'h0, bus.state}, 0);
        check("illegal_reset_flag", {31'h0, bus.illegal_op}, 0);
        rst_n = 1'b1;
`else
        check("illegal_to_fetch", {28'h0, bus.state}, 0);
        check("illegal_flag_tied", {31'h0, bus.illegal_op}, 0);
`endif

        bus.opcode = LW;
        step();
        step();
        step();
        check("midreset_memrd", {28'h0, bus.state}, 3);
        rst_n = 1'b0;
        step();
        check("midreset_state", {28'h0, bus.state}, 0);
        check("midreset_regwrite", {31'h0, bus.RegWrite}, 0);
        rst_n = 1'b1;
        step();
        check("release_first_edge", {28'h0, bus.state}, 1);

        repeat (3000) begin
            step();
            if (hold > 0) begin
                hold--;
                if (hold == 0) rst_n = 1'b1;
            end else if (m_state == 15) begin
                err_cycles++;
                if (err_cycles >= 10) begin
                    rst_n = 1'b0;
                    hold = $urandom_range(1, 2);
                    err_cycles = 0;
                end
            end else if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                hold = $urandom_range(1, 3);
            end
            case (m_state)
                0: begin cur_op = pick_op(); bus.opcode = 6'($urandom); end
                1: bus.opcode = cur_op;
                2: bus.opcode = ($urandom_range(0, 5) == 0) ? ((cur_op == LW) ? SW : LW) : cur_op;
                default: bus.opcode = 6'($urandom);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
